// File: rtl/me_pkg.sv
// me_pkg: shared definitions for the motion-estimation controller.
//   - default block geometry and the derived candidate RANGE
//   - controller state enum
//   - shift-direction encodings for the search-pixel array
//   - tag carried down the SAD pipeline alongside each issued position
package me_pkg;

  localparam int unsigned MACRO_DIM_DEF  = 16;
  localparam int unsigned SEARCH_DIM_DEF = 48;
  localparam int unsigned PIPE_LAT_DEF   = 2;
  localparam int unsigned COORD_W        = 6;

  // Number of candidate positions along one axis of the search window.
  function automatic int unsigned range_of(input int unsigned macro_dim,
                                           input int unsigned search_dim);
    return search_dim - macro_dim + 1;
  endfunction

  localparam int unsigned RANGE = range_of(MACRO_DIM_DEF, SEARCH_DIM_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CPR,
    S_LOAD_SPR,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [1:0] SEL_DOWN = 2'b00;
  localparam logic [1:0] SEL_UP   = 2'b01;
  localparam logic [1:0] SEL_LEFT = 2'b10;

  // One issued candidate: vld marks a real issue, x/y its motion vector.
  typedef struct packed {
    logic               vld;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } tag_t;

endpackage

// File: rtl/me_tag_delay.sv
// me_tag_delay: fixed-depth shift register that carries the {valid, x, y}
// tag of each issued candidate alongside the SAD datapath, so the tag leaves
// exactly when the matching SAD reaches the comparator.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high clear of every stage
//   tag_i  in   tag entering the line this cycle (all-zero = bubble)
//   tag_o  out  tag that entered DEPTH cycles ago (registered)
module me_tag_delay
  import me_pkg::*;
#(
  parameter int unsigned DEPTH = PIPE_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  // The line advances every cycle; stalls show up as bubbles, not holds.
  always_comb begin
    stage_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: this storage is reset on purpose: a stale valid left in the line would strobe the comparator after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/me_controller.sv
// me_controller: sequencer for the full-search motion-estimation datapath.
// Loads the 16x16 current block, the first 16 rows of the search window,
// then walks all RANGE x RANGE candidates in serpentine order (even columns
// downward, odd columns upward), steering the pixel-array shifts and
// strobing the comparator PIPE_LAT cycles after each issue.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a search (sampled only in IDLE)
//   pix_valid           fetch unit has this cycle's data; low = stall
//   busy, done          registered run status / end-of-run pulse
//   en_cpr, en_spr      shift enables (current / search pixel registers)
//   sel                 search-array shift direction
//   valid, addr, amt    registered comparator strobe, mv_y, mv_x
//   cpr_row             current-block row requested this cycle
//   fetch_x, fetch_y    search-window column/row consumed this cycle
module me_controller
  import me_pkg::*;
#(
  parameter int unsigned MACRO_DIM  = MACRO_DIM_DEF,
  parameter int unsigned SEARCH_DIM = SEARCH_DIM_DEF,
  parameter int unsigned PIPE_LAT   = PIPE_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pix_valid,
  output logic       busy,
  output logic       done,
  output logic       en_cpr,
  output logic       en_spr,
  output logic [1:0] sel,
  output logic       valid,
  output logic [5:0] addr,
  output logic [5:0] amt,
  output logic [3:0] cpr_row,
  output logic [5:0] fetch_x,
  output logic [5:0] fetch_y
);

  localparam logic [5:0] POS_MAX   = 6'(range_of(MACRO_DIM, SEARCH_DIM) - 1);
  localparam logic [5:0] MB_DIM    = 6'(MACRO_DIM);
  localparam logic [3:0] LOAD_MAX  = 4'(MACRO_DIM - 1);
  localparam logic [3:0] DRAIN_MAX = 4'(PIPE_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] ld_cnt_q, ld_cnt_d;
  logic [5:0] pos_x_q, pos_x_d;
  logic [5:0] pos_y_q, pos_y_d;
  logic       dn_q, dn_d;
  logic       first_q, first_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [5:0] step_x, step_y;
  logic       step_dn;
  logic       col_end;
  tag_t       issue_tag;
  tag_t       tag_out;

  // The current column is exhausted once y hits the edge it is heading to.
  assign col_end = dn_q ? (pos_y_q == POS_MAX) : (pos_y_q == 6'd0);

  // NOTE: every signal written here gets a default first; a branch that skipped one would infer a latch.
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    dn_d        = dn_q;
    first_d     = first_q;
    drain_cnt_d = drain_cnt_q;
    step_x      = pos_x_q;
    step_y      = pos_y_q;
    step_dn     = dn_q;
    issue_tag   = '0;
    en_cpr      = 1'b0;
    en_spr      = 1'b0;
    sel         = SEL_DOWN;
    cpr_row     = 4'd0;
    fetch_x     = 6'd0;
    fetch_y     = 6'd0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD_CPR;
          ld_cnt_d = 4'd0;
        end
      end

      // Row request is held while stalled so the fetch unit sees a stable
      // address until it can deliver.
      S_LOAD_CPR: begin
        cpr_row = ld_cnt_q;
        if (pix_valid) begin
          en_cpr = 1'b1;
          if (ld_cnt_q == LOAD_MAX) begin
            ld_cnt_d = 4'd0;
            state_d  = S_LOAD_SPR;
          end else begin
            ld_cnt_d = ld_cnt_q + 4'd1;
          end
        end
      end

      // Rows 0..MACRO_DIM-1 of column strip 0 shift in downward; afterwards
      // candidate (0,0) sits in the array.
      S_LOAD_SPR: begin
        sel     = SEL_DOWN;
        fetch_y = {2'b00, ld_cnt_q};
        if (pix_valid) begin
          en_spr = 1'b1;
          if (ld_cnt_q == LOAD_MAX) begin
            ld_cnt_d = 4'd0;
            pos_x_d  = 6'd0;
            pos_y_d  = 6'd0;
            dn_d     = 1'b1;
            first_d  = 1'b1;
            state_d  = S_SCAN;
          end else begin
            ld_cnt_d = ld_cnt_q + 4'd1;
          end
        end
      end

      S_SCAN: begin
        if (first_q) begin
          // (0,0) is already resident, so it issues without a shift.
          issue_tag = '{vld: 1'b1, x: pos_x_q, y: pos_y_q};
          first_d   = 1'b0;
        end else begin
          if (!col_end) begin
            fetch_x = pos_x_q;
            if (dn_q) begin
              // Entering row is the new bottom edge: new y + MACRO_DIM - 1.
              sel     = SEL_DOWN;
              fetch_y = pos_y_q + MB_DIM;
              step_y  = pos_y_q + 6'd1;
            end else begin
              sel     = SEL_UP;
              fetch_y = pos_y_q - 6'd1;
              step_y  = pos_y_q - 6'd1;
            end
          end else begin
            // Column turn: shift in the new rightmost column, reverse sweep.
            sel     = SEL_LEFT;
            fetch_x = pos_x_q + MB_DIM;
            fetch_y = pos_y_q;
            step_x  = pos_x_q + 6'd1;
            step_dn = ~dn_q;
          end

          if (pix_valid) begin
            en_spr    = 1'b1;
            pos_x_d   = step_x;
            pos_y_d   = step_y;
            dn_d      = step_dn;
            issue_tag = '{vld: 1'b1, x: step_x, y: step_y};
            if ((step_x == POS_MAX) && (step_y == POS_MAX)) begin
              drain_cnt_d = 4'd0;
              state_d     = S_DRAIN;
            end
          end
        end
      end

      // Let the last PIPE_LAT issues reach the comparator.
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_MAX) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flops look one state ahead so they line up with state_q.
    busy_d = state_d inside {S_LOAD_CPR, S_LOAD_SPR, S_SCAN, S_DRAIN};
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= 4'd0;
      pos_x_q     <= 6'd0;
      pos_y_q     <= 6'd0;
      dn_q        <= 1'b1;
      first_q     <= 1'b0;
      drain_cnt_q <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dn_q        <= dn_d;
      first_q     <= first_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  me_tag_delay #(
    .DEPTH(PIPE_LAT)
  ) u_tag_delay (
    .clk  (clk),
    .rst  (rst),
    .tag_i(issue_tag),
    .tag_o(tag_out)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = tag_out.vld;
  assign amt   = tag_out.x;
  assign addr  = tag_out.y;

endmodule

// File: tb/tb_me_controller.sv
module tb_me_controller;
  import me_pkg::*;

  localparam int PIPE_LAT = 2;
  localparam int RNG      = int'(RANGE);
  localparam int NPOS     = RNG * RNG;
  localparam int NOM_DONE = 1122 + PIPE_LAT;
  localparam int MAXC     = 1400;

  logic       clk = 1'b0;
  logic       rst, start, pix_valid;
  logic       busy, done, en_cpr, en_spr, valid;
  logic [1:0] sel;
  logic [5:0] addr, amt, fetch_x, fetch_y;
  logic [3:0] cpr_row;

  always #5 clk = ~clk;

  me_controller #(
    .MACRO_DIM (16),
    .SEARCH_DIM(48),
    .PIPE_LAT  (PIPE_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pix_valid(pix_valid),
    .busy     (busy),
    .done     (done),
    .en_cpr   (en_cpr),
    .en_spr   (en_spr),
    .sel      (sel),
    .valid    (valid),
    .addr     (addr),
    .amt      (amt),
    .cpr_row  (cpr_row),
    .fetch_x  (fetch_x),
    .fetch_y  (fetch_y)
  );

  typedef struct packed {
    logic       pv;
    logic       en_cpr;
    logic       en_spr;
    logic       valid;
    logic       busy;
    logic       done;
    logic [1:0] sel;
    logic [3:0] cpr_row;
    logic [5:0] fx;
    logic [5:0] fy;
  } samp_t;

  samp_t tr [MAXC];
  int    got_x[$], got_y[$];
  int    ex_x [NPOS];
  int    ex_y [NPOS];
  bit    stall_at [MAXC];
  int    done_rel, done_cnt, post_bad;
  int    total = 0;
  int    bad   = 0;

  // Reference order: column by column, even columns top-down, odd bottom-up.
  function automatic void build_model();
    int n = 0;
    for (int x = 0; x < RNG; x++) begin
      for (int j = 0; j < RNG; j++) begin
        ex_x[n] = x;
        ex_y[n] = (x % 2 == 0) ? j : (RNG - 1 - j);
        n++;
      end
    end
  endfunction

  function automatic void clear_stalls();
    for (int i = 0; i < MAXC; i++) stall_at[i] = 1'b0;
  endfunction

  // One full search: start at rel 0, pix_valid low where stall_at says,
  // optional extra start pulse at poke_rel. Trace sampled on negedge.
  task automatic do_run(input int poke_rel);
    int rel;
    got_x.delete();
    got_y.delete();
    done_rel = -1;
    done_cnt = 0;
    post_bad = 0;
    for (int i = 0; i < MAXC; i++) tr[i] = '0;
    @(posedge clk); #1;
    start     = 1'b1;
    pix_valid = 1'b1;
    rel       = 0;
    while (done_rel < 0 && rel < MAXC) begin
      @(negedge clk);
      tr[rel] = '{pv: pix_valid, en_cpr: en_cpr, en_spr: en_spr, valid: valid,
                  busy: busy, done: done, sel: sel, cpr_row: cpr_row,
                  fx: fetch_x, fy: fetch_y};
      if (valid) begin
        got_x.push_back(int'(amt));
        got_y.push_back(int'(addr));
      end
      if (done) begin
        done_rel = rel;
        done_cnt++;
      end
      @(posedge clk); #1;
      rel++;
      start     = (rel == poke_rel);
      pix_valid = (rel < MAXC) ? !stall_at[rel] : 1'b1;
    end
    start     = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || done || valid || en_spr || en_cpr || (amt != 0) || (addr != 0)) post_bad++;
      @(posedge clk); #1;
    end
  endtask

  function automatic int seq_errs();
    int e = 0;
    if (got_x.size() != NPOS) e++;
    for (int i = 0; i < NPOS && i < got_x.size(); i++)
      if (got_x[i] != ex_x[i] || got_y[i] != ex_y[i]) e++;
    return e;
  endfunction

  function automatic int cpr_errs();
    int n = 0, e = 0;
    for (int r = 0; r < MAXC; r++) begin
      if (tr[r].en_cpr) begin
        if (!tr[r].pv || tr[r].cpr_row != 4'(n)) e++;
        n++;
      end
    end
    if (n != 16) e++;
    return e;
  endfunction

  // Geometry of each shift: which window row/column the move brings in.
  function automatic int spr_errs();
    int n = 0, e = 0, k;
    logic [1:0] es;
    int efx, efy;
    for (int r = 0; r < MAXC; r++) begin
      if (tr[r].en_spr) begin
        if (!tr[r].pv) e++;
        if (n < 16) begin
          if (tr[r].sel != SEL_DOWN || tr[r].fx != 0 || int'(tr[r].fy) != n) e++;
        end else begin
          k = n - 16;
          if (k + 1 < NPOS) begin
            if (ex_x[k+1] != ex_x[k]) begin
              es = SEL_LEFT; efx = ex_x[k+1] + 15; efy = ex_y[k+1];
            end else if (ex_y[k+1] > ex_y[k]) begin
              es = SEL_DOWN; efx = ex_x[k]; efy = ex_y[k+1] + 15;
            end else begin
              es = SEL_UP; efx = ex_x[k]; efy = ex_y[k+1];
            end
            if (tr[r].sel != es || int'(tr[r].fx) != efx || int'(tr[r].fy) != efy) e++;
          end
        end
        n++;
      end
    end
    if (n != 16 + NPOS - 1) e++;
    return e;
  endfunction

  function automatic int busy_errs();
    int e = 0;
    if (done_rel < 1) return 1;
    if (tr[0].busy || tr[done_rel].busy) e++;
    for (int r = 1; r < done_rel; r++) if (!tr[r].busy) e++;
    return e;
  endfunction

  function automatic int first_valid_rel();
    for (int r = 0; r < MAXC; r++) if (tr[r].valid) return r;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, en_cpr, en_spr, valid, sel, addr, amt, cpr_row, fetch_x, fetch_y} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b en_cpr=%b en_spr=%b valid=%b sel=%b addr=%0d amt=%0d want all 0",
               busy, done, en_cpr, en_spr, valid, sel, addr, amt);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, en_cpr, en_spr, valid} !== 5'b0) begin
      bad++;
      $display("FAIL idle_no_start: busy=%b done=%b en_cpr=%b en_spr=%b valid=%b want 0",
               busy, done, en_cpr, en_spr, valid);
    end
  endtask

  task automatic test_nominal();
    int e;
    clear_stalls();
    do_run(-1);
    e = seq_errs();
    total++;
    if (e !== 0) begin bad++; $display("FAIL nominal_order: %0d bad entries (count %0d, want %0d)", e, got_x.size(), NPOS); end
    total++;
    if (done_rel !== NOM_DONE) begin bad++; $display("FAIL nominal_done_cycle: got %0d want %0d", done_rel, NOM_DONE); end
    total++;
    if (done_cnt !== 1 || post_bad !== 0) begin bad++; $display("FAIL nominal_done_pulse: pulses %0d idle_errs %0d want 1/0", done_cnt, post_bad); end
    e = cpr_errs();
    total++;
    if (e !== 0) begin bad++; $display("FAIL nominal_load_cpr: %0d errors want 0", e); end
    e = spr_errs();
    total++;
    if (e !== 0) begin bad++; $display("FAIL nominal_spr_shifts: %0d errors want 0", e); end
    total++;
    if (first_valid_rel() !== 33 + PIPE_LAT) begin bad++; $display("FAIL nominal_first_valid: got %0d want %0d", first_valid_rel(), 33 + PIPE_LAT); end
    e = busy_errs();
    total++;
    if (e !== 0) begin bad++; $display("FAIL nominal_busy: %0d errors want 0", e); end
  endtask

  task automatic test_column_turn();
    int n = 0, r_turn = -1, r_next = -1;
    clear_stalls();
    do_run(-1);
    for (int r = 0; r < MAXC; r++) begin
      if (tr[r].en_spr) begin
        if (n == 16 + 32) r_turn = r;
        if (n == 16 + 33) r_next = r;
        n++;
      end
    end
    total++;
    if (r_turn < 0 || tr[r_turn].sel !== SEL_LEFT || tr[r_turn].fx !== 6'd16 || tr[r_turn].fy !== 6'd32) begin
      bad++;
      $display("FAIL turn_left: at %0d sel=%b fx=%0d fy=%0d want sel=10 fx=16 fy=32",
               r_turn, tr[r_turn < 0 ? 0 : r_turn].sel, tr[r_turn < 0 ? 0 : r_turn].fx, tr[r_turn < 0 ? 0 : r_turn].fy);
    end
    total++;
    if (r_next < 0 || tr[r_next].sel !== SEL_UP || tr[r_next].fy !== 6'd31 || tr[r_next].fx !== 6'd1) begin
      bad++;
      $display("FAIL turn_then_up: at %0d sel=%b fx=%0d fy=%0d want sel=01 fx=1 fy=31",
               r_next, tr[r_next < 0 ? 0 : r_next].sel, tr[r_next < 0 ? 0 : r_next].fx, tr[r_next < 0 ? 0 : r_next].fy);
    end
  endtask

  task automatic test_stalls();
    int e;
    clear_stalls();
    for (int i = 0; i < 5; i++) stall_at[40 + i * 200 + int'($urandom_range(0, 150))] = 1'b1;
    do_run(-1);
    e = seq_errs();
    total++;
    if (e !== 0) begin bad++; $display("FAIL stall_order: %0d bad entries (count %0d, want %0d)", e, got_x.size(), NPOS); end
    total++;
    if (done_rel !== NOM_DONE + 5) begin bad++; $display("FAIL stall_done_cycle: got %0d want %0d", done_rel, NOM_DONE + 5); end
    e = spr_errs();
    total++;
    if (e !== 0) begin bad++; $display("FAIL stall_spr_shifts: %0d errors want 0", e); end
  endtask

  task automatic test_start_while_busy();
    int e;
    clear_stalls();
    do_run(500);
    e = seq_errs();
    total++;
    if (e !== 0) begin bad++; $display("FAIL busy_start_order: %0d bad entries want 0", e); end
    total++;
    if (done_rel !== NOM_DONE || done_cnt !== 1 || post_bad !== 0) begin
      bad++;
      $display("FAIL busy_start_done: cycle %0d pulses %0d idle_errs %0d want %0d/1/0", done_rel, done_cnt, post_bad, NOM_DONE);
    end
  endtask

  task automatic test_reset_mid();
    int rel, seen, e;
    clear_stalls();
    @(posedge clk); #1;
    start = 1'b1; pix_valid = 1'b1; rel = 0;
    while (rel < 33 + 7 * RNG + (RNG - 1 - 10)) begin
      @(posedge clk); #1;
      rel++;
      start = 1'b0;
    end
    @(negedge clk);
    total++;
    if (en_spr !== 1'b1 || sel !== SEL_UP || fetch_x !== 6'd7 || fetch_y !== 6'd10) begin
      bad++;
      $display("FAIL rstmid_at_7_10: en_spr=%b sel=%b fx=%0d fy=%0d want 1/01/7/10", en_spr, sel, fetch_x, fetch_y);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, valid, done, en_spr, en_cpr} !== 5'b0) begin
      bad++;
      $display("FAIL rstmid_idle: busy=%b valid=%b done=%b en_spr=%b en_cpr=%b want 0", busy, valid, done, en_spr, en_cpr);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (valid || done || busy) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rstmid_quiet: %0d active cycles want 0", seen); end
    do_run(-1);
    e = seq_errs();
    total++;
    if (e !== 0 || done_rel !== NOM_DONE) begin
      bad++;
      $display("FAIL rstmid_rerun: %0d bad entries, done at %0d want 0/%0d", e, done_rel, NOM_DONE);
    end
  endtask

  task automatic test_load_stall();
    int e = 0;
    clear_stalls();
    for (int r = 6; r <= 8; r++) stall_at[r] = 1'b1;
    do_run(-1);
    for (int r = 6; r <= 8; r++) if (tr[r].en_cpr !== 1'b0 || tr[r].cpr_row !== 4'd5) e++;
    total++;
    if (e !== 0) begin bad++; $display("FAIL load_stall_hold: %0d bad cycles want 0", e); end
    total++;
    if (tr[9].en_cpr !== 1'b1 || tr[9].cpr_row !== 4'd5 || tr[10].cpr_row !== 4'd6) begin
      bad++;
      $display("FAIL load_stall_resume: en_cpr=%b row=%0d next_row=%0d want 1/5/6", tr[9].en_cpr, tr[9].cpr_row, tr[10].cpr_row);
    end
    e = cpr_errs() + seq_errs();
    total++;
    if (e !== 0 || done_rel !== NOM_DONE + 3) begin
      bad++;
      $display("FAIL load_stall_run: %0d errors, done at %0d want 0/%0d", e, done_rel, NOM_DONE + 3);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0;
    build_model();
    test_reset();
    test_nominal();
    test_column_turn();
    test_stalls();
    test_start_while_busy();
    test_reset_mid();
    test_load_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
